// File: rtl/pixel_packer_pkg.sv
// Shared types for the pixel packer: packed AXI-Stream word plus its
// frame-end tag, and the fixed pixel/bus widths.
package pixel_packer_pkg;

   localparam int PACK_PIX_W  = 8;
   localparam int AXIS_DATA_W = 32;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0] data;
      logic                   last;
      logic                   user;
      logic                   eof;
   } axis_word_t;

endpackage

// File: rtl/pixel_packer_fifo.sv
// First-word-fall-through FIFO for packed words; head is visible on dout
// whenever not empty, pointers carry one wrap bit so full/empty are exact.
module pixel_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   output logic                   full,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic             w_pop;
   logic             w_push;

   assign level  = r_wr - r_rd;
   assign empty  = (r_wr == r_rd);
   assign full   = (level == (AW+1)'(DEPTH));
   assign w_pop  = pop && !empty;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign w_push = push && (!full || w_pop);
   assign dout   = empty ? '0 : r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/pixel_packer.sv
// Quantises shaded pixels to 8 bits, packs four per 32-bit word and streams
// them out over AXI4-Stream with line (tlast) and frame (tuser) markers.
module pixel_packer
   import pixel_packer_pkg::*;
#(
   parameter int COLOR_WIDTH = 8,
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_gen,
   input  logic [COLOR_WIDTH-1:0]        shade_in,
   input  logic                          valid_in,
   input  logic                          sync,
   input  logic                          clear_ovf,
   output logic [AXIS_DATA_W-1:0]        m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   output logic                          overflow,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int XW = $clog2(H_RES);
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_RES - 4);
   localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

   if (H_RES % 4 != 0) begin : g_hres_chk
      $error("pixel_packer: H_RES must be a multiple of 4");
   end
   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("pixel_packer: FIFO_DEPTH must be a power of two >= 4");
   end

   logic [PACK_PIX_W-1:0] w_pix;

   if (COLOR_WIDTH >= PACK_PIX_W) begin : g_q_msb
      assign w_pix = shade_in[COLOR_WIDTH-1 -: PACK_PIX_W];
   end else begin : g_q_pad
      assign w_pix = {shade_in, {(PACK_PIX_W-COLOR_WIDTH){1'b0}}};
   end

   logic [2:0][PACK_PIX_W-1:0] r_lane;
   logic [1:0]                 r_idx;
   logic [XW-1:0]              r_x;
   logic [YW-1:0]              r_y;
   logic                       r_ovf;
   logic                       r_fd;

   logic [2:0][PACK_PIX_W-1:0] w_lane_n;
   logic [1:0]                 w_idx;
   logic [1:0]                 w_idx_n;
   logic [XW-1:0]              w_x;
   logic [XW-1:0]              w_x_n;
   logic [YW-1:0]              w_y;
   logic [YW-1:0]              w_y_n;
   logic                       w_done;
   axis_word_t                 w_word;
   axis_word_t                 w_dout;
   logic                       w_full;
   logic                       w_empty;
   logic                       w_hs;
   logic                       w_drop;

   // sync zeroes the position first, so a pixel in the same cycle is (0,0) lane 0
   always_comb begin
      w_idx    = sync ? 2'd0 : r_idx;
      w_x      = sync ? '0 : r_x;
      w_y      = sync ? '0 : r_y;
      w_lane_n = sync ? '0 : r_lane;
      w_idx_n  = w_idx;
      w_x_n    = w_x;
      w_y_n    = w_y;
      w_done   = valid_in && (w_idx == 2'd3);
      w_word.data = {w_pix, r_lane[2], r_lane[1], r_lane[0]};
      w_word.last = (w_x == X_LAST);
      w_word.user = (w_x == '0) && (w_y == '0);
      w_word.eof  = (w_x == X_LAST) && (w_y == Y_LAST);
      if (valid_in) begin
         w_idx_n = w_idx + 2'd1;
         for (int i = 0; i < 3; i++) begin
            if (w_idx == 2'(i)) w_lane_n[i] = w_pix;
         end
      end
      // position advances even when the word is dropped
      if (w_done) begin
         if (w_x == X_LAST) begin
            w_x_n = '0;
            w_y_n = (w_y == Y_LAST) ? '0 : w_y + 1'b1;
         end else begin
            w_x_n = w_x + XW'(4);
         end
      end
   end

   assign w_hs   = m_axis_tvalid && m_axis_tready;
   assign w_drop = w_done && w_full && !w_hs;

   always_ff @(posedge clk or negedge rst_gen) begin
      if (!rst_gen) begin
         r_lane <= '0;
         r_idx  <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_ovf  <= 1'b0;
         r_fd   <= 1'b0;
      end else begin
         r_lane <= w_lane_n;
         r_idx  <= w_idx_n;
         r_x    <= w_x_n;
         r_y    <= w_y_n;
         r_fd   <= w_hs && w_dout.eof;
         if (w_drop)         r_ovf <= 1'b1;
         else if (clear_ovf) r_ovf <= 1'b0;
      end
   end

   pixel_fifo #(
      .WIDTH ($bits(axis_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_gen),
      .push  (w_done),
      .din   (w_word),
      .full  (w_full),
      .pop   (m_axis_tready),
      .dout  (w_dout),
      .empty (w_empty),
      .level (fifo_level)
   );

   assign m_axis_tvalid = !w_empty;
   assign m_axis_tdata  = w_dout.data;
   assign m_axis_tlast  = w_dout.last;
   assign m_axis_tuser  = w_dout.user;
   assign overflow      = r_ovf;
   assign frame_done    = r_fd;

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench for pixel_packer: a pixel-count model predicts stored
// words, FIFO occupancy and overflow; a negedge monitor checks each handshake.
module tb_pixel_packer;
   import pixel_packer_pkg::*;

   localparam int H   = 8;
   localparam int V   = 2;
   localparam int D   = 16;
   localparam int CW  = 8;
   localparam int PPF = H * V;

   logic          clk = 1'b0;
   logic          rst_gen = 1'b0;
   logic [CW-1:0] shade_in = '0;
   logic          valid_in = 1'b0;
   logic          sync = 1'b0;
   logic          clear_ovf = 1'b0;
   logic [31:0]   m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
   logic          overflow;
   logic          frame_done;
   logic [$clog2(D):0] fifo_level;

   always #5 clk = ~clk;

   pixel_packer #(
      .COLOR_WIDTH (CW),
      .H_RES       (H),
      .V_RES       (V),
      .FIFO_DEPTH  (D)
   ) dut (
      .clk           (clk),
      .rst_gen       (rst_gen),
      .shade_in      (shade_in),
      .valid_in      (valid_in),
      .sync          (sync),
      .clear_ovf     (clear_ovf),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .overflow      (overflow),
      .frame_done    (frame_done),
      .fifo_level    (fifo_level)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: frame position is just the pixel count since frame start
   int          pc = 0;
   logic [7:0]  lanes [4];
   axis_word_t  mq [$];
   axis_word_t  sbq [$];
   bit          exp_ovf = 1'b0;

   function automatic axis_word_t make_word();
      axis_word_t w;
      int wi = pc / 4;
      int x  = (wi * 4) % H;
      int y  = (wi * 4) / H;
      w.data = {lanes[3], lanes[2], lanes[1], lanes[0]};
      w.last = (x == H - 4);
      w.user = (wi == 0);
      w.eof  = (x == H - 4) && (y == V - 1);
      return w;
   endfunction

   // called at posedge+2; drives one cycle and checks the result after the edge
   task automatic cycle(input bit v, input logic [7:0] pix, input bit s,
                        input bit rdy, input bit clr);
      axis_word_t wd;
      bit pop, push, drop;
      valid_in      = v;
      shade_in      = pix;
      sync          = s;
      m_axis_tready = rdy;
      clear_ovf     = clr;
      pop  = (mq.size() > 0) && rdy;
      push = 1'b0;
      wd   = '0;
      if (s) pc = 0;
      if (v) begin
         lanes[pc % 4] = pix;
         if (pc % 4 == 3) begin
            wd   = make_word();
            push = 1'b1;
         end
         pc = (pc + 1) % PPF;
      end
      drop = push && (mq.size() == D) && !pop;
      if (drop)     exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push && !drop) begin
         mq.push_back(wd);
         sbq.push_back(wd);
      end
      @(posedge clk);
      #2;
      chk("level", 64'(fifo_level), 64'(mq.size()));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      chk("tvalid", 64'(m_axis_tvalid), 64'(mq.size() > 0));
   endtask

   task automatic drain();
      int n = 0;
      while (mq.size() > 0 && n < 200) begin
         cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         n++;
      end
      chk("drain_bound", 64'(mq.size()), 64'd0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   // monitor: handshake happens at the next posedge with these sampled values
   bit          mon_en = 1'b0;
   bit          pend_fd = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last, prev_user;
   int          fd_seen = 0;
   axis_word_t  me;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("frame_done", 64'(frame_done), 64'(pend_fd));
         if (frame_done) fd_seen++;
         if (prev_stall) begin
            chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
            chk("stall_data", 64'(m_axis_tdata), 64'(prev_data));
            chk("stall_lu", 64'({m_axis_tlast, m_axis_tuser}),
                64'({prev_last, prev_user}));
         end
         pend_fd = 1'b0;
         if (m_axis_tvalid && m_axis_tready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty: got word %0h expected none", m_axis_tdata);
            end else begin
               me = sbq.pop_front();
               chk("tdata", 64'(m_axis_tdata), 64'(me.data));
               chk("tlast", 64'(m_axis_tlast), 64'(me.last));
               chk("tuser", 64'(m_axis_tuser), 64'(me.user));
               pend_fd = me.eof;
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
         prev_user  = m_axis_tuser;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
      chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
      chk({tag, "_lu"}, 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
      chk({tag, "_ovf"}, 64'(overflow), 64'd0);
      chk({tag, "_fd"}, 64'(frame_done), 64'd0);
      chk({tag, "_level"}, 64'(fifo_level), 64'd0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2;
      rst_gen    = 1'b1;
      pc         = 0;
      exp_ovf    = 1'b0;
      mq.delete();
      sbq.delete();
      pend_fd    = 1'b0;
      prev_stall = 1'b0;
      mon_en     = 1'b1;
   endtask

   initial begin
      int fd0, npix;
      #1;
      check_reset_outputs("por");
      repeat (3) @(posedge clk);
      release_reset();

      // continuous 0x10..0x1F, one full frame
      fd0 = fd_seen;
      for (int i = 0; i < 16; i++)
         cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b1, 1'b0);
      drain();
      chk("pack_fd_count", 64'(fd_seen - fd0), 64'd1);

      // stall for 20 words, then release
      for (int i = 0; i < 80; i++)
         cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      chk("stall_level", 64'(fifo_level), 64'(D));
      chk("stall_ovf", 64'(overflow), 64'd1);
      drain();
      for (int i = 0; i < 16; i++)
         cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
      drain();

      // full FIFO with push and pop on the same edge
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 64 + 3; i++)
         cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
      chk("pushpop_ovf", 64'(overflow), 64'd0);
      drain();

      // sync mid-word with a pixel in the same cycle
      cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b1, 1'b0);
      drain();

      // asynchronous reset with three words held
      for (int i = 0; i < 12; i++)
         cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      chk("prerst_level", 64'(fifo_level), 64'd3);
      #1;
      mon_en  = 1'b0;
      rst_gen = 1'b0;
      #1;
      check_reset_outputs("arst");
      valid_in      = 1'b0;
      m_axis_tready = 1'b0;
      release_reset();

      // random valid/ready over three frames
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      fd0  = fd_seen;
      npix = 0;
      while (npix < 3 * PPF) begin
         bit v = ($urandom_range(9) < 7);
         cycle(v, 8'($urandom), 1'b0, 1'($urandom_range(1)), 1'b0);
         if (v) npix++;
      end
      drain();
      chk("rand_fd_count", 64'(fd_seen - fd0), 64'd3);
      chk("sb_leftover", 64'(sbq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
